// File: rtl/cv32e41p_div_prep.sv
// cv32e41p_div_prep
//   Front end for a serial divider. It accepts one divide/remainder request,
//   normalises the divisor (left shift by its redundant leading bits), issues
//   the operands to the divider, and returns the divider result through a
//   valid/ready response port. Only one request is in flight at a time.
//
// Ports
//   Clk_CI, Rst_RI            clock (rising edge), synchronous active-high reset
//   Req_Vld_SI / Req_Rdy_SO   request handshake
//   Req_OpA_DI, Req_OpB_DI    dividend, divisor
//   Req_OpCode_SI             bit0 signed, bit1 remainder (0 udiv,1 div,2 urem,3 rem)
//   Rsp_Vld_SO / Rsp_Rdy_SI   response handshake, Rsp_Res_DO result
//   Div_OpA_DO, Div_OpB_DO    dividend, shifted divisor to the divider
//   Div_OpBShift_DO           divisor shift count
//   Div_OpBIsZero_SO          divisor is zero
//   Div_OpBSign_SO            divisor is negative (signed ops only)
//   Div_OpCode_SO             registered opcode
//   Div_InVld_SO              one-cycle issue strobe
//   Div_OutVld_SI / Div_OutRdy_SO, Div_Res_DI  divider result handshake
//
// Build option
//   CV32E41P_DIV_ZERO_BYPASS_EN: a zero divisor skips the divider and answers
//   directly (all-ones for div, OpA for rem).

module cv32e41p_div_prep #(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned C_LOG_WIDTH = 6
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RI,
  input  logic                   Req_Vld_SI,
  output logic                   Req_Rdy_SO,
  input  logic [C_WIDTH-1:0]     Req_OpA_DI,
  input  logic [C_WIDTH-1:0]     Req_OpB_DI,
  input  logic [1:0]             Req_OpCode_SI,
  output logic                   Rsp_Vld_SO,
  input  logic                   Rsp_Rdy_SI,
  output logic [C_WIDTH-1:0]     Rsp_Res_DO,
  output logic [C_WIDTH-1:0]     Div_OpA_DO,
  output logic [C_WIDTH-1:0]     Div_OpB_DO,
  output logic [C_LOG_WIDTH-1:0] Div_OpBShift_DO,
  output logic                   Div_OpBIsZero_SO,
  output logic                   Div_OpBSign_SO,
  output logic [1:0]             Div_OpCode_SO,
  output logic                   Div_InVld_SO,
  input  logic                   Div_OutVld_SI,
  output logic                   Div_OutRdy_SO,
  input  logic [C_WIDTH-1:0]     Div_Res_DI
);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [C_WIDTH-1:0]     opa_q, opa_d;
  logic [C_WIDTH-1:0]     opb_q, opb_d;
  logic [1:0]             opcode_q, opcode_d;
  logic [C_WIDTH-1:0]     opb_shift_q, opb_shift_d;
  logic [C_LOG_WIDTH-1:0] shift_q, shift_d;
  logic                   zero_q, zero_d;
  logic                   sign_q, sign_d;
  logic [C_WIDTH-1:0]     res_q, res_d;

  logic [C_WIDTH-1:0]     scan;
  logic                   ref_bit;
  logic                   run;
  logic [C_LOG_WIDTH-1:0] lead_cnt;
  logic [C_LOG_WIDTH-1:0] shift_calc;

  // Leading-bit count: zeros for unsigned ops, copies of the sign bit for
  // signed ops (always >= 1 there, since the MSB matches itself).
  always_comb begin
    scan     = opb_q;
    ref_bit  = opb_q[C_WIDTH-1] & opcode_q[0];
    run      = 1'b1;
    lead_cnt = '0;
    for (int unsigned i = 0; i < C_WIDTH; i++) begin
      if (run && (scan[C_WIDTH-1] == ref_bit)) begin
        lead_cnt = lead_cnt + C_LOG_WIDTH'(1);
      end else begin
        run = 1'b0;
      end
      scan = scan << 1;
    end
  end

  // Signed: keep one sign bit. Unsigned: a zero divisor counts C_WIDTH, clamp.
  always_comb begin
    if (opcode_q[0]) begin
      shift_calc = lead_cnt - C_LOG_WIDTH'(1);
    end else if (lead_cnt == C_LOG_WIDTH'(C_WIDTH)) begin
      shift_calc = C_LOG_WIDTH'(C_WIDTH - 1);
    end else begin
      shift_calc = lead_cnt;
    end
  end

  always_comb begin
    state_d       = state_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    opcode_d      = opcode_q;
    opb_shift_d   = opb_shift_q;
    shift_d       = shift_q;
    zero_d        = zero_q;
    sign_d        = sign_q;
    res_d         = res_q;
    Req_Rdy_SO    = 1'b0;
    Div_InVld_SO  = 1'b0;
    Div_OutRdy_SO = 1'b0;
    Rsp_Vld_SO    = 1'b0;

    unique case (state_q)
      IDLE: begin
        Req_Rdy_SO = 1'b1;
        if (Req_Vld_SI) begin
          opa_d    = Req_OpA_DI;
          opb_d    = Req_OpB_DI;
          opcode_d = Req_OpCode_SI;
          state_d  = PREP;
        end
      end
      PREP: begin
        shift_d     = shift_calc;
        opb_shift_d = opb_q << shift_calc;
        zero_d      = (opb_q == '0);
        sign_d      = opb_q[C_WIDTH-1] & opcode_q[0];
        state_d     = ISSUE;
`ifdef CV32E41P_DIV_ZERO_BYPASS_EN
        if (opb_q == '0) begin
          res_d   = opcode_q[1] ? opa_q : '1;
          state_d = RESP;
        end
`endif
      end
      ISSUE: begin
        Div_InVld_SO = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        Div_OutRdy_SO = 1'b1;
        if (Div_OutVld_SI) begin
          res_d   = Div_Res_DI;
          state_d = RESP;
        end
      end
      RESP: begin
        Rsp_Vld_SO = 1'b1;
        if (Rsp_Rdy_SI) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q     <= IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      opcode_q    <= '0;
      opb_shift_q <= '0;
      shift_q     <= '0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      opcode_q    <= opcode_d;
      opb_shift_q <= opb_shift_d;
      shift_q     <= shift_d;
      zero_q      <= zero_d;
      sign_q      <= sign_d;
      res_q       <= res_d;
    end
  end

  assign Rsp_Res_DO       = res_q;
  assign Div_OpA_DO       = opa_q;
  assign Div_OpB_DO       = opb_shift_q;
  assign Div_OpBShift_DO  = shift_q;
  assign Div_OpBIsZero_SO = zero_q;
  assign Div_OpBSign_SO   = sign_q;
  assign Div_OpCode_SO    = opcode_q;

endmodule

// File: tb/tb_cv32e41p_div_prep.sv
// Bench for cv32e41p_div_prep: a table of requests with hand-derived
// divisor normalisation and results, a behavioural serial-divider stub that
// recomputes the result from the operands the DUT issues, and a scoreboard
// that checks every response against the table entry.

module tb_cv32e41p_div_prep;

  localparam int W = 32;
`ifdef CV32E41P_DIV_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_vld, req_rdy;
  logic [W-1:0]  req_a, req_b;
  logic [1:0]    req_op;
  logic          rsp_vld, rsp_rdy;
  logic [W-1:0]  rsp_res;
  logic [W-1:0]  div_a, div_b;
  logic [5:0]    div_shift;
  logic          div_zero, div_sign;
  logic [1:0]    div_op;
  logic          div_in_vld, div_out_vld, div_out_rdy;
  logic [W-1:0]  div_res;

  always #5 clk = ~clk;

  cv32e41p_div_prep #(.C_WIDTH(32), .C_LOG_WIDTH(6)) dut (
    .Clk_CI          (clk),
    .Rst_RI          (rst),
    .Req_Vld_SI      (req_vld),
    .Req_Rdy_SO      (req_rdy),
    .Req_OpA_DI      (req_a),
    .Req_OpB_DI      (req_b),
    .Req_OpCode_SI   (req_op),
    .Rsp_Vld_SO      (rsp_vld),
    .Rsp_Rdy_SI      (rsp_rdy),
    .Rsp_Res_DO      (rsp_res),
    .Div_OpA_DO      (div_a),
    .Div_OpB_DO      (div_b),
    .Div_OpBShift_DO (div_shift),
    .Div_OpBIsZero_SO(div_zero),
    .Div_OpBSign_SO  (div_sign),
    .Div_OpCode_SO   (div_op),
    .Div_InVld_SO    (div_in_vld),
    .Div_OutVld_SI   (div_out_vld),
    .Div_OutRdy_SO   (div_out_rdy),
    .Div_Res_DI      (div_res)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Divider stub ----------------------------------------------------------
  int          stub_lat  = 1;
  bit          junk_en   = 1'b0;
  int          invld_cnt = 0;
  logic        stub_vld  = 1'b0;
  logic [W-1:0] stub_res = '0;

  // Junk result offered during the issue cycle must be ignored.
  assign div_out_vld = stub_vld | (junk_en & div_in_vld);
  assign div_res     = (junk_en & div_in_vld) ? 32'hDEADBEEF : stub_res;

  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
    logic signed [W-1:0] sa, sbv;
    sa  = a;
    sbv = b;
    if (b == 0) return op[1] ? a : 32'hFFFFFFFF;
    if (op[0]) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'h0 : a;
      return op[1] ? 32'(sa % sbv) : 32'(sa / sbv);
    end
    return op[1] ? a % b : a / b;
  endfunction

  initial begin
    logic [W-1:0]        a, b, r;
    logic signed [W-1:0] bsig;
    logic [1:0]          op;
    forever begin
      @(posedge clk); #1;
      if (div_in_vld === 1'b1) begin
        invld_cnt++;
        a  = div_a;
        op = div_op;
        if (op[0]) begin
          bsig = $signed(div_b);
          b    = bsig >>> div_shift;
        end else begin
          b = div_b >> div_shift;
        end
        r = ref_div(a, b, op);
        @(posedge clk); #1;
        check("invld_single_cycle", {31'b0, div_in_vld}, 32'd0);
        repeat (stub_lat - 1) begin
          @(posedge clk); #1;
        end
        stub_res = r;
        stub_vld = 1'b1;
        @(posedge clk); #1;
        stub_vld = 1'b0;
      end
    end
  end

  // Scoreboard ------------------------------------------------------------
  typedef struct {
    logic [W-1:0] res;
    logic [5:0]   shift;
    logic [W-1:0] opb_sh;
    logic         sign;
    logic         zero;
    int           lat;
    int           n_invld;
    int           invld_base;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];

  initial begin
    bit   seen;
    exp_t e;
    logic [W-1:0] held;
    seen = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst === 1'b1 || rsp_vld !== 1'b1) begin
        seen = 1'b0;
      end else if (!seen) begin
        seen = 1'b1;
        held = rsp_res;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: actual response %h required none (t=%0t)", rsp_res, $time);
        end else begin
          e = sb.pop_front();
          check("rsp_res",   rsp_res,                        e.res);
          check("shift",     {26'b0, div_shift},             {26'b0, e.shift});
          check("opb_shift", div_b,                          e.opb_sh);
          check("sign",      {31'b0, div_sign},              {31'b0, e.sign});
          check("zero",      {31'b0, div_zero},              {31'b0, e.zero});
          check("latency",   32'(cyc - e.acc_cyc),           32'(e.lat));
          check("invld_cnt", 32'(invld_cnt - e.invld_base),  32'(e.n_invld));
        end
      end else begin
        check("rsp_stable", rsp_res, held);
      end
    end
  end

  // Driver ----------------------------------------------------------------
  int acc_cyc;

  // Called #1 after a clock edge; returns #1 after the acceptance edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    int g;
    req_vld = 1'b1;
    req_a   = a;
    req_b   = b;
    req_op  = op;
    g = 0;
    while (req_rdy !== 1'b1 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_accept_timeout: actual not ready required ready");
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_vld = 1'b0;
  endtask

  task automatic push_exp(input logic [W-1:0] res, input logic [5:0] shift,
                          input logic [W-1:0] opb_sh, input logic sign, input logic zero,
                          input int lat_div);
    exp_t e;
    bit   byp;
    byp          = BYP && zero;
    e.res        = res;
    e.shift      = shift;
    e.opb_sh     = opb_sh;
    e.sign       = sign;
    e.zero       = zero;
    e.lat        = byp ? 2 : 3 + lat_div;
    e.n_invld    = byp ? 0 : 1;
    e.invld_base = invld_cnt;
    e.acc_cyc    = 0;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while ((sb.size() != 0 || req_rdy !== 1'b1) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_timeout: actual no response required response");
    end
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [5:0]   shift;
    logic [W-1:0] opb_sh;
    logic         sign;
    logic         zero;
    logic [W-1:0] res;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #2000000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int g;
    logic [W-1:0] held;

    //            op     a             b             sh  opb_sh        sg  z   res
    tbl[0]  = '{2'd0, 32'd100,      32'd7,        6'd29, 32'hE0000000, 0, 0, 32'd14};
    tbl[1]  = '{2'd3, 32'hFFFFFFF9, 32'd2,        6'd29, 32'h40000000, 0, 0, 32'hFFFFFFFF};
    tbl[2]  = '{2'd1, 32'd20,       32'hFFFFFFFF, 6'd31, 32'h80000000, 1, 0, 32'hFFFFFFEC};
    tbl[3]  = '{2'd2, 32'hFFFFFFFF, 32'h10,       6'd27, 32'h80000000, 0, 0, 32'hF};
    tbl[4]  = '{2'd0, 32'h80000000, 32'h80000000, 6'd0,  32'h80000000, 0, 0, 32'd1};
    tbl[5]  = '{2'd1, 32'h80000000, 32'hFFFFFFFF, 6'd31, 32'h80000000, 1, 0, 32'h80000000};
    tbl[6]  = '{2'd3, 32'd100,      32'hFFFFFFF9, 6'd28, 32'h90000000, 1, 0, 32'd2};
    tbl[7]  = '{2'd0, 32'd5,        32'd0,        6'd31, 32'h0,        0, 1, 32'hFFFFFFFF};
    tbl[8]  = '{2'd3, 32'd12,       32'd0,        6'd31, 32'h0,        0, 1, 32'd12};
    tbl[9]  = '{2'd1, 32'h7FFFFFFF, 32'd3,        6'd29, 32'h60000000, 0, 0, 32'h2AAAAAAA};
    tbl[10] = '{2'd1, 32'hFFFFFF9C, 32'd7,        6'd28, 32'h70000000, 0, 0, 32'hFFFFFFF2};
    tbl[11] = '{2'd2, 32'h12345678, 32'h100,      6'd23, 32'h80000000, 0, 0, 32'h78};
    tbl[12] = '{2'd1, 32'd1,        32'h40000000, 6'd0,  32'h40000000, 0, 0, 32'd0};
    tbl[13] = '{2'd3, 32'hFFFFFFFF, 32'h80000000, 6'd0,  32'h80000000, 1, 0, 32'hFFFFFFFF};
    tbl[14] = '{2'd2, 32'hFFFFFFFF, 32'd0,        6'd31, 32'h0,        0, 1, 32'hFFFFFFFF};

    rst     = 1'b1;
    req_vld = 1'b0;
    req_a   = '0;
    req_b   = '0;
    req_op  = '0;
    rsp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_rdy",   {31'b0, req_rdy},     32'd1);
    check("rst_rsp_vld",   {31'b0, rsp_vld},     32'd0);
    check("rst_rsp_res",   rsp_res,              32'd0);
    check("rst_div_a",     div_a,                32'd0);
    check("rst_div_b",     div_b,                32'd0);
    check("rst_shift",     {26'b0, div_shift},   32'd0);
    check("rst_zero",      {31'b0, div_zero},    32'd0);
    check("rst_sign",      {31'b0, div_sign},    32'd0);
    check("rst_opcode",    {30'b0, div_op},      32'd0);
    check("rst_in_vld",    {31'b0, div_in_vld},  32'd0);
    check("rst_out_rdy",   {31'b0, div_out_rdy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      stub_lat = 1 + (i % 4) * 3;
      junk_en  = (i % 3 == 0);
      push_exp(tbl[i].res, tbl[i].shift, tbl[i].opb_sh, tbl[i].sign, tbl[i].zero, stub_lat);
      send(tbl[i].a, tbl[i].b, tbl[i].op);
      sb[sb.size()-1].acc_cyc = acc_cyc;
      wait_done();
    end
    junk_en = 1'b0;

    // Response back-pressure: 1000/10 -> 100, lz(10)=28.
    stub_lat = 2;
    rsp_rdy  = 1'b0;
    push_exp(32'd100, 6'd28, 32'hA0000000, 1'b0, 1'b0, stub_lat);
    send(32'd1000, 32'd10, 2'd0);
    sb[sb.size()-1].acc_cyc = acc_cyc;
    g = 0;
    while (rsp_vld !== 1'b1 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    held = rsp_res;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_rsp_vld", {31'b0, rsp_vld}, 32'd1);
      check("bp_rsp_res", rsp_res,          held);
      check("bp_req_rdy", {31'b0, req_rdy}, 32'd0);
    end
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    check("bp_release_req_rdy", {31'b0, req_rdy}, 32'd1);
    check("bp_release_rsp_vld", {31'b0, rsp_vld}, 32'd0);
    wait_done();

    // Reset while the divider is busy: no response may follow.
    stub_lat = 8;
    send(32'd55, 32'd5, 2'd0);
    g = 0;
    while (div_out_rdy !== 1'b1 && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    check("abort_reached_wait", {31'b0, div_out_rdy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_req_rdy", {31'b0, req_rdy},     32'd1);
    check("abort_rsp_vld", {31'b0, rsp_vld},     32'd0);
    check("abort_out_rdy", {31'b0, div_out_rdy}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (rsp_vld === 1'b1) cnt++;
    end
    check("abort_no_rsp", 32'(cnt), 32'd0);

    // Recovery after the abort.
    stub_lat = 3;
    push_exp(tbl[0].res, tbl[0].shift, tbl[0].opb_sh, tbl[0].sign, tbl[0].zero, stub_lat);
    send(tbl[0].a, tbl[0].b, tbl[0].op);
    sb[sb.size()-1].acc_cyc = acc_cyc;
    wait_done();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e41p_div_prep.md
CV32E41P_DIV_PREP -- requirements
Module: cv32e41p_div_prep

Interface
REQ-001 SHALL have parameter C_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter C_LOG_WIDTH, default 6, shift-count width, equal to $clog2(C_WIDTH+1).
REQ-003 SHALL have port Clk_CI  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port Rst_RI  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports Req_Vld_SI in 1, Req_Rdy_SO out 1  upstream request handshake.
REQ-006 SHALL have ports Req_OpA_DI in C_WIDTH, Req_OpB_DI in C_WIDTH  dividend, divisor.
REQ-007 SHALL have port Req_OpCode_SI  in  2  bit0 signed, bit1 remainder (0 udiv, 1 div, 2 urem, 3 rem).
REQ-008 SHALL have ports Rsp_Vld_SO out 1, Rsp_Rdy_SI in 1, Rsp_Res_DO out C_WIDTH  result handshake.
REQ-009 SHALL have ports Div_OpA_DO, Div_OpB_DO out C_WIDTH; Div_OpBShift_DO out C_LOG_WIDTH; Div_OpBIsZero_SO, Div_OpBSign_SO out 1; Div_OpCode_SO out 2  serial-divider operands.
REQ-010 SHALL have ports Div_InVld_SO out 1, Div_OutVld_SI in 1, Div_OutRdy_SO out 1, Div_Res_DI in C_WIDTH  serial-divider handshake.

Function
REQ-011 SHALL implement FSM states IDLE, PREP, ISSUE, WAIT, RESP.
REQ-012 IDLE: Req_Rdy_SO=1; on Req_Vld_SI, SHALL register OpA, OpB, OpCode and go to PREP; all other states drive Req_Rdy_SO=0.
REQ-013 PREP: SHALL compute and register the shift count, the shifted divisor, the zero flag and the sign flag, then go to ISSUE.
REQ-014 Sign flag SHALL be OpB[MSB] & OpCode[0]; zero flag SHALL be (OpB==0).
REQ-015 Unsigned ops: shift SHALL be the count of leading zeros of OpB, clamped to C_WIDTH-1.
REQ-016 Signed ops: shift SHALL be (count of leading bits equal to OpB[MSB]) minus 1, clamped to 0..C_WIDTH-1.
REQ-017 Div_OpB_DO SHALL be the registered OpB logically shifted left by the shift count; Div_OpA_DO and Div_OpCode_SO SHALL be the registered values.
REQ-018 ISSUE: Div_InVld_SO=1 for exactly one cycle, then go to WAIT.
REQ-019 WAIT: Div_OutRdy_SO=1; Div_OutVld_SI SHALL be ignored in the ISSUE cycle; on Div_OutVld_SI in WAIT, SHALL capture Div_Res_DI into the result register and go to RESP.
REQ-020 RESP: Rsp_Vld_SO=1 and Rsp_Res_DO stable until Rsp_Rdy_SI; on Rsp_Rdy_SI, go to IDLE.
REQ-021 Div_InVld_SO, Div_OutRdy_SO and Rsp_Vld_SO SHALL be 0 outside ISSUE, WAIT and RESP respectively.
REQ-022 Single outstanding request; the earliest new acceptance SHALL be the cycle after the RESP handshake.
REQ-023 Latency from acceptance to Rsp_Vld_SO through the divider SHALL be 2 + divider cycles + 1.
REQ-024 Rsp_Vld_SO SHALL NOT depend combinationally on Rsp_Rdy_SI; Req_Rdy_SO SHALL NOT depend on Req_Vld_SI.

Reset
REQ-025 Reset SHALL force IDLE and clear all registers, giving Req_Rdy_SO=1, all other outputs 0.
REQ-026 Reset asserted in any state SHALL abort the operation at the next edge with no response; the divider shares the reset.

Configuration
REQ-027 Macro CV32E41P_DIV_ZERO_BYPASS_EN, when defined: a zero divisor in PREP SHALL skip ISSUE/WAIT and go straight to RESP with result all-ones (opcode 0/1) or OpA (opcode 2/3), latency 2.
REQ-028 When the macro is undefined, every request, including a zero divisor, SHALL pass through the divider.

Verification
REQ-029 udiv A=100, B=7 -> Div_OpBShift_DO=29, Div_OpB_DO=0xE0000000, one Div_InVld pulse, Rsp_Res_DO=14.
REQ-030 rem A=-7 (0xFFFFFFF9), B=2 -> Div_OpBSign_SO=0, shift=29, Rsp_Res_DO=0xFFFFFFFF.
REQ-031 div A=20, B=-1 -> shift=31, Div_OpBSign_SO=1, Rsp_Res_DO=0xFFFFFFEC.
REQ-032 udiv B=0 with macro defined -> no Div_InVld pulse, Rsp_Vld 2 cycles after acceptance, Res=0xFFFFFFFF; macro undefined -> Div_InVld pulse, Div_OpBIsZero_SO=1.
REQ-033 Hold Rsp_Rdy_SI=0 for 10 cycles in RESP -> Rsp_Vld_SO and Rsp_Res_DO stable, Req_Rdy_SO=0; then Rdy=1 -> IDLE next cycle.
REQ-034 Assert Rst_RI during WAIT -> next cycle IDLE, Req_Rdy_SO=1, Rsp_Vld_SO=0, and no response is ever produced.
